alu_op_decoder: RTL and testbench

Decode stage that accepts 32-bit MIPS32 instruction words on a valid/ready stream and produces the ALU's control bundle. The bundle covers the 4-bit ALU selector, the signed-overflow select, carry-in, operand-source selects, the expanded immediate and the destination register, so the ALU can be driven directly. It sits between instruction fetch and the register-read/ALU stage. A 2-entry skid buffer keeps `in_ready` registered and gives full throughput under backpressure.

---
 rtl/alu_op_decoder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_alu_op_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_decoder.sv
// MIPS32 decode stage: turns instruction words into an ALU control bundle and
// buffers decoded bundles in a 2-entry skid FIFO with a registered in_ready.
module alu_op_decoder #(
  parameter int unsigned ILLEGAL_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               alu_sel,
  output logic                     sign,
  output logic                     carry_in,
  output logic                     a_src,
  output logic [1:0]               b_src,
  output logic [31:0]              imm,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               dst,
  output logic                     reg_write,
  output logic                     illegal,
  output logic [ILLEGAL_CNT_W-1:0] illegal_count
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_MUL = 4'h2,
    ALU_LUI = 4'h3,
    ALU_SLL = 4'h4,
    ALU_SRL = 4'h5,
    ALU_SRA = 4'h7,
    ALU_AND = 4'h8,
    ALU_OR  = 4'h9,
    ALU_XOR = 4'hA,
    ALU_NOR = 4'hB,
    ALU_CLZ = 4'hC,
    ALU_CLO = 4'hD,
    ALU_SLT = 4'hE,
    ALU_SEQ = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    B_RT    = 2'd0,
    B_SIMM  = 2'd1,
    B_ZIMM  = 2'd2,
    B_SHAMT = 2'd3
  } b_src_e;

  typedef enum logic [5:0] {
    OP_SPECIAL  = 6'h00,
    OP_BEQ      = 6'h04,
    OP_BNE      = 6'h05,
    OP_ADDI     = 6'h08,
    OP_ADDIU    = 6'h09,
    OP_SLTI     = 6'h0A,
    OP_SLTIU    = 6'h0B,
    OP_ANDI     = 6'h0C,
    OP_ORI      = 6'h0D,
    OP_XORI     = 6'h0E,
    OP_LUI      = 6'h0F,
    OP_SPECIAL2 = 6'h1C,
    OP_LW       = 6'h23,
    OP_SW       = 6'h2B
  } opcode_e;

  typedef struct packed {
    alu_op_e     alu_sel;
    logic        sign;
    logic        carry_in;
    logic        a_src;
    b_src_e      b_src;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        reg_write;
    logic        illegal;
  } bundle_t;

  logic [5:0]  f_op;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_shamt;
  logic [5:0]  f_funct;
  logic [15:0] f_imm;
  logic [31:0] simm;
  logic [31:0] zimm;

  assign f_op    = in_instr[31:26];
  assign f_rs    = in_instr[25:21];
  assign f_rt    = in_instr[20:16];
  assign f_rd    = in_instr[15:11];
  assign f_shamt = in_instr[10:6];
  assign f_funct = in_instr[5:0];
  assign f_imm   = in_instr[15:0];
  assign simm    = {{16{f_imm[15]}}, f_imm};
  assign zimm    = {16'b0, f_imm};

  bundle_t dec;

  // Defaults describe the illegal bundle; each legal encoding overrides it.
  always_comb begin
    dec           = '0;
    dec.rs        = f_rs;
    dec.rt        = f_rt;
    dec.dst       = f_rd;
    dec.imm       = zimm;
    dec.illegal   = 1'b1;
    case (f_op)
      OP_SPECIAL: begin
        dec.illegal   = 1'b0;
        dec.reg_write = 1'b1;
        case (f_funct)
          6'h20: begin dec.alu_sel = ALU_ADD; dec.sign = 1'b1; end
          6'h21: dec.alu_sel = ALU_ADD;
          6'h22: begin dec.alu_sel = ALU_SUB; dec.sign = 1'b1; end
          6'h23: dec.alu_sel = ALU_SUB;
          6'h24: dec.alu_sel = ALU_AND;
          6'h25: dec.alu_sel = ALU_OR;
          6'h26: dec.alu_sel = ALU_XOR;
          6'h27: dec.alu_sel = ALU_NOR;
          6'h2A: begin dec.alu_sel = ALU_SLT; dec.sign = 1'b1; end
          6'h2B: dec.alu_sel = ALU_SLT;
          6'h00, 6'h02, 6'h03: begin
            dec.alu_sel = (f_funct == 6'h00) ? ALU_SLL :
                          (f_funct == 6'h02) ? ALU_SRL : ALU_SRA;
            dec.a_src   = 1'b1;
            dec.b_src   = B_SHAMT;
            dec.imm     = {27'b0, f_shamt};
          end
          6'h04, 6'h06, 6'h07: begin
            dec.alu_sel = (f_funct == 6'h04) ? ALU_SLL :
                          (f_funct == 6'h06) ? ALU_SRL : ALU_SRA;
            dec.a_src   = 1'b1;
          end
          default: begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      OP_SPECIAL2: begin
        dec.illegal   = 1'b0;
        dec.reg_write = 1'b1;
        case (f_funct)
          6'h02:   dec.alu_sel = ALU_MUL;
          6'h20:   dec.alu_sel = ALU_CLZ;
          6'h21:   dec.alu_sel = ALU_CLO;
          default: begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        dec.illegal   = 1'b0;
        dec.reg_write = 1'b1;
        dec.dst       = f_rt;
        dec.b_src     = B_SIMM;
        dec.imm       = simm;
        dec.alu_sel   = (f_op == OP_SLTI || f_op == OP_SLTIU) ? ALU_SLT : ALU_ADD;
        dec.sign      = (f_op == OP_ADDI || f_op == OP_SLTI);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.illegal   = 1'b0;
        dec.reg_write = 1'b1;
        dec.dst       = f_rt;
        dec.b_src     = B_ZIMM;
        dec.alu_sel   = (f_op == OP_ANDI) ? ALU_AND :
                        (f_op == OP_ORI)  ? ALU_OR  :
                        (f_op == OP_XORI) ? ALU_XOR : ALU_LUI;
      end
      OP_SW: begin
        dec.illegal   = 1'b0;
        dec.dst       = f_rt;
        dec.b_src     = B_SIMM;
        dec.imm       = simm;
        dec.alu_sel   = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        dec.illegal   = 1'b0;
        dec.dst       = f_rt;
        dec.alu_sel   = ALU_SEQ;
      end
      default: ;
    endcase
  end

  // Skid buffer: e0 drives the outputs, e1 catches the word accepted while full-pending.
  bundle_t                  e0_q, e0_d;
  bundle_t                  e1_q, e1_d;
  logic [1:0]               cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic [ILLEGAL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic                     accept;
  logic                     deliver;

  always_comb begin
    e0_d      = e0_q;
    e1_d      = e1_q;
    cnt_d     = cnt_q;
    ill_cnt_d = ill_cnt_q;
    deliver   = (cnt_q != 2'd0) && out_ready;
    accept    = in_valid && in_ready_q && !flush;

    if (deliver && e0_q.illegal && (ill_cnt_q != '1)) begin
      ill_cnt_d = ill_cnt_q + 1'b1;
    end

    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (accept) begin
            e0_d  = dec;
            cnt_d = 2'd1;
          end
        end
        2'd1: begin
          if (accept && deliver) begin
            e0_d = dec;
          end else if (accept) begin
            e1_d  = dec;
            cnt_d = 2'd2;
          end else if (deliver) begin
            cnt_d = 2'd0;
          end
        end
        default: begin
          // in_ready is low whenever two entries are held, so only a drain can happen.
          if (deliver) begin
            e0_d  = e1_q;
            cnt_d = 2'd1;
          end
        end
      endcase
    end

    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q       <= '0;
      e1_q       <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      ill_cnt_q  <= '0;
    end else begin
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (cnt_q != 2'd0);
  assign alu_sel       = e0_q.alu_sel;
  assign sign          = e0_q.sign;
  assign carry_in      = e0_q.carry_in;
  assign a_src         = e0_q.a_src;
  assign b_src         = e0_q.b_src;
  assign imm           = e0_q.imm;
  assign rs            = e0_q.rs;
  assign rt            = e0_q.rt;
  assign dst           = e0_q.dst;
  assign reg_write     = e0_q.reg_write;
  assign illegal       = e0_q.illegal;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode table, backpressure, saturation, flush, reset.
module tb_alu_op_decoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_sel;
  logic        sign;
  logic        carry_in;
  logic        a_src;
  logic [1:0]  b_src;
  logic [31:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  dst;
  logic        reg_write;
  logic        illegal;
  logic [7:0]  illegal_count;

  int errors = 0;
  int checks = 0;

  alu_op_decoder #(.ILLEGAL_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_sel(alu_sel), .sign(sign), .carry_in(carry_in),
    .a_src(a_src), .b_src(b_src), .imm(imm),
    .rs(rs), .rt(rt), .dst(dst),
    .reg_write(reg_write), .illegal(illegal), .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NV = 18;
  logic [31:0] tv_instr [NV];
  logic [3:0]  tv_alu   [NV];
  logic        tv_sign  [NV];
  logic        tv_a     [NV];
  logic [1:0]  tv_b     [NV];
  logic [4:0]  tv_dst   [NV];
  logic        tv_rw    [NV];
  logic        tv_ill   [NV];
  logic [31:0] tv_imm   [NV];
  logic [4:0]  tv_m     [NV];  // {imm, sign, a_src, b_src, dst} fields defined for this word

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [31:0] ins, input logic [3:0] al,
                         input logic sg, input logic a, input logic [1:0] b,
                         input logic [4:0] d, input logic rw, input logic il,
                         input logic [31:0] im, input logic [4:0] m);
    tv_instr[i] = ins; tv_alu[i] = al; tv_sign[i] = sg; tv_a[i] = a; tv_b[i] = b;
    tv_dst[i] = d; tv_rw[i] = rw; tv_ill[i] = il; tv_imm[i] = im; tv_m[i] = m;
  endtask

  task automatic load_table();
    set_vec( 0, 32'h00221820, 4'h0, 1, 0, 0, 3, 1, 0, 32'h0,        5'b01111); // add
    set_vec( 1, 32'h00221822, 4'h1, 1, 0, 0, 3, 1, 0, 32'h0,        5'b01111); // sub
    set_vec( 2, 32'h00221823, 4'h1, 0, 0, 0, 3, 1, 0, 32'h0,        5'b01111); // subu
    set_vec( 3, 32'h00221825, 4'h9, 0, 0, 0, 3, 1, 0, 32'h0,        5'b00111); // or
    set_vec( 4, 32'h00221827, 4'hB, 0, 0, 0, 3, 1, 0, 32'h0,        5'b00111); // nor
    set_vec( 5, 32'h0022182B, 4'hE, 0, 0, 0, 3, 1, 0, 32'h0,        5'b01111); // sltu
    set_vec( 6, 32'h0022182A, 4'hE, 1, 0, 0, 3, 1, 0, 32'h0,        5'b01111); // slt
    set_vec( 7, 32'h00A21804, 4'h4, 0, 1, 0, 3, 1, 0, 32'h0,        5'b00111); // sllv
    set_vec( 8, 32'h00021903, 4'h7, 0, 1, 3, 3, 1, 0, 32'h4,        5'b10111); // sra
    set_vec( 9, 32'h70221802, 4'h2, 0, 0, 0, 3, 1, 0, 32'h0,        5'b00001); // mul
    set_vec(10, 32'h70221820, 4'hC, 0, 0, 0, 3, 1, 0, 32'h0,        5'b00101); // clz
    set_vec(11, 32'h3C02ABCD, 4'h3, 0, 0, 2, 2, 1, 0, 32'h0000ABCD, 5'b10011); // lui
    set_vec(12, 32'h2822FFFF, 4'hE, 1, 0, 1, 2, 1, 0, 32'hFFFFFFFF, 5'b11011); // slti
    set_vec(13, 32'h2022FFFF, 4'h0, 1, 0, 1, 2, 1, 0, 32'hFFFFFFFF, 5'b11011); // addi
    set_vec(14, 32'h8C220010, 4'h0, 0, 0, 1, 2, 1, 0, 32'h10,       5'b11011); // lw
    set_vec(15, 32'hAC220010, 4'h0, 0, 0, 1, 0, 0, 0, 32'h10,       5'b11010); // sw
    set_vec(16, 32'h14220003, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0,        5'b00010); // bne
    set_vec(17, 32'h0022183F, 4'h0, 0, 0, 0, 3, 0, 1, 32'h0,        5'b01011); // bad funct
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (illegal_count !== 8'd0) begin errors++; $display("FAIL reset_illegal_count got %0d exp 0", illegal_count); end
    checks++; if ({alu_sel, sign, carry_in, a_src, b_src, imm, rs, rt, dst, reg_write, illegal} !== '0) begin
      errors++; $display("FAIL reset_bundle got alu=%h imm=%h dst=%0d rw=%b ill=%b exp all zero", alu_sel, imm, dst, reg_write, illegal);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_decode_stream();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = tv_instr[i];
      cyc();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL stream%0d_handshake got ov=%b ir=%b exp 1 1", i, out_valid, in_ready);
      end
      checks++; if (alu_sel !== tv_alu[i]) begin errors++; $display("FAIL stream%0d_alu got %h exp %h", i, alu_sel, tv_alu[i]); end
      checks++; if (reg_write !== tv_rw[i]) begin errors++; $display("FAIL stream%0d_rw got %b exp %b", i, reg_write, tv_rw[i]); end
      checks++; if (illegal !== tv_ill[i]) begin errors++; $display("FAIL stream%0d_illegal got %b exp %b", i, illegal, tv_ill[i]); end
      checks++; if (carry_in !== 1'b0) begin errors++; $display("FAIL stream%0d_carry got %b exp 0", i, carry_in); end
      checks++; if (rs !== tv_instr[i][25:21] || rt !== tv_instr[i][20:16]) begin
        errors++; $display("FAIL stream%0d_rs_rt got %0d %0d exp %0d %0d", i, rs, rt, tv_instr[i][25:21], tv_instr[i][20:16]);
      end
      if (tv_m[i][4]) begin checks++; if (imm !== tv_imm[i]) begin errors++; $display("FAIL stream%0d_imm got %h exp %h", i, imm, tv_imm[i]); end end
      if (tv_m[i][3]) begin checks++; if (sign !== tv_sign[i]) begin errors++; $display("FAIL stream%0d_sign got %b exp %b", i, sign, tv_sign[i]); end end
      if (tv_m[i][2]) begin checks++; if (a_src !== tv_a[i]) begin errors++; $display("FAIL stream%0d_a_src got %b exp %b", i, a_src, tv_a[i]); end end
      if (tv_m[i][1]) begin checks++; if (b_src !== tv_b[i]) begin errors++; $display("FAIL stream%0d_b_src got %0d exp %0d", i, b_src, tv_b[i]); end end
      if (tv_m[i][0]) begin checks++; if (dst !== tv_dst[i]) begin errors++; $display("FAIL stream%0d_dst got %0d exp %0d", i, dst, tv_dst[i]); end end
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got ov=%b exp 0", out_valid); end
    checks++; if (illegal_count !== 8'd1) begin errors++; $display("FAIL stream_illegal_count got %0d exp 1", illegal_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00221820;
    cyc();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first got ov=%b ir=%b exp 1 1", out_valid, in_ready);
    end
    in_instr = 32'h000521C0;
    cyc();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    in_instr = 32'h3022FFFF;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d got ir=%b ov=%b exp 0 1", k, in_ready, out_valid);
      end
      checks++; if (alu_sel !== 4'h0 || sign !== 1'b1 || dst !== 5'd3 || reg_write !== 1'b1) begin
        errors++; $display("FAIL bp_frozen%0d got alu=%h sign=%b dst=%0d exp 0 1 3", k, alu_sel, sign, dst);
      end
    end
    out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b1 || alu_sel !== 4'h4 || a_src !== 1'b1 || b_src !== 2'd3 || imm !== 32'h7 || dst !== 5'd4) begin
      errors++; $display("FAIL bp_sll got ov=%b alu=%h a=%b b=%0d imm=%h dst=%0d exp 1 4 1 3 7 4", out_valid, alu_sel, a_src, b_src, imm, dst);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
    cyc();
    checks++; if (out_valid !== 1'b1 || alu_sel !== 4'h8 || b_src !== 2'd2 || imm !== 32'h0000FFFF || dst !== 5'd2) begin
      errors++; $display("FAIL bp_andi got ov=%b alu=%h b=%0d imm=%h dst=%0d exp 1 8 2 0000ffff 2", out_valid, alu_sel, b_src, imm, dst);
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got ov=%b exp 0", out_valid); end
  endtask

  task automatic test_illegal_sat();
    int exp_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_instr = 32'hFC000000;
      cyc();
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || reg_write !== 1'b0 || alu_sel !== 4'h0) begin
        errors++; $display("FAIL ill%0d_bundle got ov=%b ill=%b rw=%b alu=%h exp 1 1 0 0", i, out_valid, illegal, reg_write, alu_sel);
      end
      checks++; if (illegal_count !== exp_cnt[7:0]) begin
        errors++; $display("FAIL ill%0d_count got %0d exp %0d", i, illegal_count, exp_cnt);
      end
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (illegal_count !== 8'd255 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ill_saturated got cnt=%0d ov=%b exp 255 0", illegal_count, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h8C220010;
    cyc();
    in_instr  = 32'hAC220010;
    cyc();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_prefill got ir=%b ov=%b exp 0 1", in_ready, out_valid);
    end
    flush    = 1'b1;
    in_instr = 32'h00221820;
    cyc();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty got ov=%b ir=%b exp 0 1", out_valid, in_ready);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d got ov=%b exp 0", k, out_valid); end
    end
    checks++; if (illegal_count !== 8'd255) begin errors++; $display("FAIL flush_keeps_count got %0d exp 255", illegal_count); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00221820;
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got ov=%b exp 1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 8'd0) begin
      errors++; $display("FAIL areset_ctrl got ov=%b ir=%b cnt=%0d exp 0 1 0", out_valid, in_ready, illegal_count);
    end
    checks++; if ({alu_sel, sign, carry_in, a_src, b_src, imm, rs, rt, dst, reg_write, illegal} !== '0) begin
      errors++; $display("FAIL areset_bundle got alu=%h sign=%b imm=%h dst=%0d rw=%b exp all zero", alu_sel, sign, imm, dst, reg_write);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_flush_delivery_counts();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hFC000000;
    cyc();
    checks++; if (out_valid !== 1'b1 || illegal_count !== 8'd0) begin
      errors++; $display("FAIL fcount_pre got ov=%b cnt=%0d exp 1 0", out_valid, illegal_count);
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || illegal_count !== 8'd1) begin
      errors++; $display("FAIL fcount_post got ov=%b cnt=%0d exp 0 1", out_valid, illegal_count);
    end
  endtask

  initial begin
    load_table();
    test_reset();
    test_decode_stream();
    test_backpressure();
    test_illegal_sat();
    test_flush();
    test_async_reset();
    test_flush_delivery_counts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
